// File: rtl/cbus_arbiter_pkg.sv
// Shared CBus types and encodings, plus the arbiter's internal state type.
// Imported by cbus_arbiter, cbus_arb_pick and the bench.
package cbus_arbiter_pkg;

  localparam int CBUS_AW = 32;
  localparam int CBUS_DW = 32;

  // Transfer size encodings (bytes per beat).
  localparam logic [1:0] CBUS_SIZE_B = 2'd0;
  localparam logic [1:0] CBUS_SIZE_H = 2'd1;
  localparam logic [1:0] CBUS_SIZE_W = 2'd2;

  // Burst length is encoded as beats minus one.
  localparam logic [3:0] CBUS_LEN_1  = 4'd0;
  localparam logic [3:0] CBUS_LEN_4  = 4'd3;
  localparam logic [3:0] CBUS_LEN_16 = 4'd15;

  typedef struct packed {
    logic               valid;
    logic               write;
    logic [1:0]         size;
    logic [3:0]         len;
    logic [CBUS_AW-1:0] addr;
    logic [CBUS_DW-1:0] wdata;
  } cbus_req_t;

  typedef struct packed {
    logic               ready;
    logic               last;
    logic [CBUS_DW-1:0] data;
  } cbus_resp_t;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/cbus_arb_pick.sv
// Winner select: first asserted request at or after 'start', wrapping modulo N.
// With start tied to zero this degenerates to lowest-index-wins priority.
module cbus_arb_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  reqs,
  input  logic [IW-1:0] start,
  output logic [IW-1:0] idx,
  output logic          found
);

  logic [N-1:0] rot;

  // rot[k] is the request that sits k positions after start.
  assign rot = N'({reqs, reqs} >> start);

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    idx   = '0;
    found = 1'b0;
    // Walk downward so the smallest offset from start is the last one written.
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        idx   = IW'((int'(start) + k) % N);
      end
    end
  end

endmodule

// File: rtl/cbus_arbiter.sv
// N:1 CBus arbiter: one grant held from arbitration until ready && last.
// Default is fixed priority; define CBUS_ARB_RR_EN for round-robin.
module cbus_arbiter
  import cbus_arbiter_pkg::*;
#(
  parameter int NUM_INPUTS = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  cbus_req_t  ireqs  [NUM_INPUTS],
  output cbus_resp_t iresps [NUM_INPUTS],
  output cbus_req_t  oreq,
  input  cbus_resp_t oresp
);

  localparam int SW = $clog2(NUM_INPUTS);

  arb_state_e            state;
  logic [SW-1:0]         sel;
  logic [SW-1:0]         start;
  logic [SW-1:0]         win;
  logic                  win_found;
  logic [NUM_INPUTS-1:0] valids;

  always_comb begin
    valids = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      valids[i] = ireqs[i].valid;
    end
  end

  cbus_arb_pick #(
    .N  (NUM_INPUTS),
    .IW (SW)
  ) u_pick (
    .reqs  (valids),
    .start (start),
    .idx   (win),
    .found (win_found)
  );

`ifdef CBUS_ARB_RR_EN
  // Pointer holds last_granted + 1, so reset to 0 makes index 0 the first candidate.
  logic [SW-1:0] rr_ptr;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rr_ptr <= '0;
    end else if (state == ARB_IDLE && win_found) begin
      rr_ptr <= (win == SW'(NUM_INPUTS - 1)) ? '0 : win + SW'(1);
    end
  end

  assign start = rr_ptr;
`else
  assign start = '0;
`endif

  // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= ARB_IDLE;
      sel   <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (win_found) begin
            sel   <= win;
            state <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          // Valid dropping mid-burst is not checked; only ready && last ends the grant.
          if (oresp.ready && oresp.last) begin
            state <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  // Pass-through muxing: only the granted port sees traffic, and only while BUSY.
  always_comb begin
    oreq = '0;
    for (int j = 0; j < NUM_INPUTS; j++) begin
      iresps[j] = '0;
      if (state == ARB_BUSY && sel == SW'(j)) begin
        oreq      = ireqs[j];
        iresps[j] = oresp;
      end
    end
  end

endmodule
